// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter: packet-granular round-robin merge of NUM_SRC byte streams
// into one registered output stream. A grant is held from a packet's first byte
// to its tlast byte. An optional stall watchdog releases a grant whose source
// stops mid-packet and raises a sticky error flag.
module packet_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [8*NUM_SRC-1:0]   i_s_tdata,
    input  logic [NUM_SRC-1:0]     i_s_tlast,
    input  logic [NUM_SRC-1:0]     i_s_tvalid,
    output logic [NUM_SRC-1:0]     o_s_tready,
    output logic [7:0]             o_m_tdata,
    output logic                   o_m_tlast,
    output logic                   o_m_tvalid,
    input  logic                   i_m_tready,
    output logic [NUM_SRC-1:0]     o_grant,
    output logic                   o_err
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] lg;
    logic [CNT_W-1:0] stall_cnt;

    logic [IDX_W-1:0] pick;
    logic             pick_hit;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             sel_valid;
    logic             load_en;
    logic             xfer;
    logic             wd_expire;

    // Output stage registers; vld_p0 travels with data_p0/last_p0.
    logic [7:0]       data_p0;
    logic             last_p0;
    logic             vld_p0;

    assign o_m_tdata  = data_p0;
    assign o_m_tlast  = last_p0;
    assign o_m_tvalid = vld_p0;

    // Round-robin scan starting just after the last-served source.
    always_comb begin
        pick     = '0;
        pick_hit = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!pick_hit && i_s_tvalid[j] && (j == (int'(lg) + k) % NUM_SRC)) begin
                    pick     = IDX_W'(j);
                    pick_hit = 1'b1;
                end
            end
        end
    end

    // Mux of the currently granted source onto the load path.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (g == IDX_W'(j)) begin
                sel_data  = i_s_tdata[8*j +: 8];
                sel_last  = i_s_tlast[j];
                sel_valid = i_s_tvalid[j];
            end
        end
    end

    // The output register can take a new byte when empty or draining this cycle;
    // this makes tready combinational from i_m_tready (no skid buffer).
    assign load_en   = !vld_p0 || i_m_tready;
    assign xfer      = (state == ST_PKT) && sel_valid && load_en;
    // A transfer in the same cycle takes precedence over expiry.
    assign wd_expire = (TIMEOUT > 0) && (state == ST_PKT) && !xfer && (stall_cnt == CNT_MAX);

    // Grant and per-source ready decoded from the registered grant index.
    always_comb begin
        o_grant    = '0;
        o_s_tready = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if ((state == ST_PKT) && (g == IDX_W'(j))) begin
                o_grant[j]    = 1'b1;
                o_s_tready[j] = load_en;
            end
        end
    end

    // Arbitration FSM, last-served pointer, stall watchdog and sticky error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            g         <= '0;
            lg        <= LAST_IDX;
            stall_cnt <= '0;
            o_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stall_cnt <= '0;
                    if (pick_hit) begin
                        g     <= pick;
                        state <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (sel_last) begin
                            lg    <= g;
                            state <= ST_IDLE;
                        end
                    end else if (wd_expire) begin
                        // Abort without fabricating tlast; later bytes form a new packet.
                        lg        <= g;
                        state     <= ST_IDLE;
                        stall_cnt <= '0;
                        o_err     <= 1'b1;
                    end else if ((TIMEOUT > 0) && !sel_valid && (stall_cnt != CNT_MAX)) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register: load on transfer, clear when drained, hold while stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            last_p0 <= 1'b0;
        end else if (xfer) begin
            vld_p0  <= 1'b1;
            data_p0 <= sel_data;
            last_p0 <= sel_last;
        end else if (i_m_tready) begin
            vld_p0  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed testbench for packet_rr_arbiter (NUM_SRC = 4, TIMEOUT = 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle c0 of each scenario is the first cycle after the setup.
module tb_packet_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [3:0]  grant;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    packet_rr_arbiter #(.NUM_SRC(4), .TIMEOUT(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_s_tdata  (s_tdata),
        .i_s_tlast  (s_tlast),
        .i_s_tvalid (s_tvalid),
        .o_s_tready (s_tready),
        .o_m_tdata  (m_tdata),
        .o_m_tlast  (m_tlast),
        .o_m_tvalid (m_tvalid),
        .i_m_tready (m_tready),
        .o_grant    (grant),
        .o_err      (err)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        next_cycle();
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tvalid = '0;
        m_tready = 1'b1;
        next_cycle();
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
        checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h want 00", m_tdata); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready: got %b want 0000", s_tready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        next_cycle();
    endtask

    task automatic test_single();
        logic [3:0] eg [0:5];
        logic       ev [0:5];
        logic [7:0] ed [0:5];
        logic       el [0:5];
        logic [7:0] bytes [0:2];
        int b = 0;
        eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43, 8'h00};
        el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bytes = '{8'h41, 8'h42, 8'h43};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            s_tvalid = (b < 3) ? 4'b0010 : 4'b0000;
            s_tdata  = '0;
            if (b < 3) s_tdata[15:8] = bytes[b];
            s_tlast  = (b == 2) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            checks++; if (grant !== eg[c]) begin errors++; $display("FAIL single_grant c%0d: got %b want %b", c, grant, eg[c]); end
            checks++; if (s_tready !== eg[c]) begin errors++; $display("FAIL single_tready c%0d: got %b want %b", c, s_tready, eg[c]); end
            checks++; if (m_tvalid !== ev[c]) begin errors++; $display("FAIL single_tvalid c%0d: got %b want %b", c, m_tvalid, ev[c]); end
            if (ev[c]) begin
                checks++;
                if ({m_tlast, m_tdata} !== {el[c], ed[c]}) begin
                    errors++; $display("FAIL single_data c%0d: got last=%b data=%h want last=%b data=%h", c, m_tlast, m_tdata, el[c], ed[c]);
                end
            end
            if (s_tvalid[1] && s_tready[1]) b++;
            next_cycle();
        end
    endtask

    task automatic test_fairness();
        int n [4];
        int got = 0;
        logic [7:0] outb [0:31];
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        n = '{0, 0, 0, 0};
        apply_reset();
        for (int c = 0; c < 26; c++) begin
            for (int k = 0; k < 4; k++) begin
                s_tvalid[k]        = 1'b1;
                s_tdata[8*k +: 8]  = {4'(k), 4'(n[k])};
                s_tlast[k]         = n[k][0];
            end
            @(negedge clk);
            exp_g = (c % 3 == 0) ? 4'b0000 : (4'b0001 << ((c / 3) % 4));
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL fair_grant c%0d: got %b want %b", c, grant, exp_g); end
            checks++; if (s_tready !== exp_g) begin errors++; $display("FAIL fair_tready c%0d: got %b want %b", c, s_tready, exp_g); end
            if (m_tvalid === 1'b1 && got < 32) begin
                checks++;
                if (m_tlast !== got[0]) begin errors++; $display("FAIL fair_tlast #%0d: got %b want %b", got, m_tlast, got[0]); end
                outb[got] = m_tdata;
                got++;
            end
            for (int k = 0; k < 4; k++) if (s_tready[k]) n[k]++;
            next_cycle();
        end
        checks++; if (got != 16) begin errors++; $display("FAIL fair_count: got %0d bytes want 16", got); end
        for (int i = 0; i < 16 && i < got; i++) begin
            exp_d = {4'((i / 2) % 4), 4'(2 * (i / 8) + (i % 2))};
            checks++; if (outb[i] !== exp_d) begin errors++; $display("FAIL fair_order #%0d: got %h want %h", i, outb[i], exp_d); end
        end
    endtask

    task automatic test_backpressure();
        logic       rdy [0:8];
        logic       er  [0:8];
        logic       ev  [0:8];
        logic [7:0] ed  [0:8];
        logic [7:0] acc [0:7];
        int b = 0;
        int na = 0;
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        er  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ev  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed  = '{8'h00, 8'h00, 8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            m_tready = rdy[c];
            s_tvalid = (b < 4) ? 4'b0001 : 4'b0000;
            s_tdata  = '0;
            s_tdata[7:0] = 8'hA0 + 8'(b);
            s_tlast  = (b == 3) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            checks++; if (s_tready[0] !== er[c]) begin errors++; $display("FAIL bp_tready c%0d: got %b want %b", c, s_tready[0], er[c]); end
            checks++; if (m_tvalid !== ev[c]) begin errors++; $display("FAIL bp_tvalid c%0d: got %b want %b", c, m_tvalid, ev[c]); end
            if (ev[c]) begin
                checks++; if (m_tdata !== ed[c]) begin errors++; $display("FAIL bp_data c%0d: got %h want %h", c, m_tdata, ed[c]); end
            end
            if (m_tvalid === 1'b1 && m_tready && na < 8) begin
                acc[na] = m_tdata;
                na++;
            end
            if (s_tvalid[0] && s_tready[0]) b++;
            next_cycle();
        end
        m_tready = 1'b1;
        checks++; if (na != 4) begin errors++; $display("FAIL bp_count: got %0d bytes want 4", na); end
        for (int i = 0; i < 4 && i < na; i++) begin
            checks++; if (acc[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL bp_seq #%0d: got %h want %h", i, acc[i], 8'hA0 + 8'(i)); end
        end
    endtask

    task automatic test_watchdog();
        int b2 = 0;
        int b3 = 0;
        logic [3:0] exp_g;
        logic       exp_e;
        logic       exp_v;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            s_tvalid = {(b3 < 1), (b2 < 1), 2'b00};
            s_tdata  = {8'h66, 8'h55, 16'h0000};
            s_tlast  = 4'b1000;
            @(negedge clk);
            exp_g = (c >= 1 && c <= 10) ? 4'b0100 : (c == 12) ? 4'b1000 : 4'b0000;
            exp_e = (c >= 11);
            exp_v = (c == 2 || c == 13);
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL wd_grant c%0d: got %b want %b", c, grant, exp_g); end
            checks++; if (s_tready !== exp_g) begin errors++; $display("FAIL wd_tready c%0d: got %b want %b", c, s_tready, exp_g); end
            checks++; if (err !== exp_e) begin errors++; $display("FAIL wd_err c%0d: got %b want %b", c, err, exp_e); end
            checks++; if (m_tvalid !== exp_v) begin errors++; $display("FAIL wd_tvalid c%0d: got %b want %b", c, m_tvalid, exp_v); end
            if (c == 2) begin
                checks++; if ({m_tlast, m_tdata} !== {1'b0, 8'h55}) begin errors++; $display("FAIL wd_byte2: got last=%b data=%h want last=0 data=55", m_tlast, m_tdata); end
            end
            if (c == 13) begin
                checks++; if ({m_tlast, m_tdata} !== {1'b1, 8'h66}) begin errors++; $display("FAIL wd_byte3: got last=%b data=%h want last=1 data=66", m_tlast, m_tdata); end
            end
            if (s_tvalid[2] && s_tready[2]) b2++;
            if (s_tvalid[3] && s_tready[3]) b3++;
            next_cycle();
        end
    endtask

    // Runs straight after the watchdog scenario so o_err is set on entry.
    task automatic test_reset_mid_packet();
        int b = 0;
        logic [3:0] done = 4'b0000;
        for (int c = 0; c < 7; c++) begin
            rst_n = (c == 2) ? 1'b0 : 1'b1;
            if (c < 3) begin
                s_tvalid = (b < 4) ? 4'b0001 : 4'b0000;
                s_tdata  = {24'h0, 8'hB0 + 8'(b)};
                s_tlast  = (b == 3) ? 4'b0001 : 4'b0000;
            end else begin
                s_tvalid = ~done;
                s_tdata  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
                s_tlast  = 4'b1111;
            end
            @(negedge clk);
            if (c == 2) begin
                checks++; if ({m_tvalid, m_tdata, err} !== {1'b1, 8'hB0, 1'b1}) begin errors++; $display("FAIL rmid_pre: got v=%b d=%h err=%b want v=1 d=b0 err=1", m_tvalid, m_tdata, err); end
            end
            if (c == 3) begin
                checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b want 0", m_tvalid); end
                checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rmid_grant: got %b want 0000", grant); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", err); end
                checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL rmid_tready: got %b want 0000", s_tready); end
                checks++; if ({m_tlast, m_tdata} !== 9'h000) begin errors++; $display("FAIL rmid_data: got last=%b data=%h want 0/00", m_tlast, m_tdata); end
            end
            if (c == 4) begin
                checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant: got %b want 0001", grant); end
            end
            if (c == 5) begin
                checks++; if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b1, 8'hC0}) begin errors++; $display("FAIL rmid_first_byte: got v=%b l=%b d=%h want 1/1/c0", m_tvalid, m_tlast, m_tdata); end
            end
            if (c == 6) begin
                checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rmid_second_grant: got %b want 0010", grant); end
            end
            if (c < 3) begin
                if (s_tvalid[0] && s_tready[0]) b++;
            end else begin
                done = done | (s_tvalid & s_tready);
            end
            next_cycle();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        logic [3:0] eg [0:7];
        logic       ev [0:7];
        logic [8:0] ed [0:7];
        logic [7:0] d0 [0:2];
        logic       l0 [0:2];
        int b0 = 0;
        int b1 = 0;
        eg = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0};
        ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ed = '{9'h000, 9'h000, 9'h0D0, 9'h1D1, 9'h000, 9'h1F0, 9'h000, 9'h1E0};
        d0 = '{8'hD0, 8'hD1, 8'hE0};
        l0 = '{1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            s_tvalid = {2'b00, (b1 < 1), (b0 < 3)};
            s_tdata  = '0;
            s_tdata[15:8] = 8'hF0;
            if (b0 < 3) s_tdata[7:0] = d0[b0];
            s_tlast  = {2'b00, 1'b1, (b0 < 3) ? l0[b0] : 1'b0};
            @(negedge clk);
            checks++; if (grant !== eg[c]) begin errors++; $display("FAIL simul_grant c%0d: got %b want %b", c, grant, eg[c]); end
            checks++; if (m_tvalid !== ev[c]) begin errors++; $display("FAIL simul_tvalid c%0d: got %b want %b", c, m_tvalid, ev[c]); end
            if (ev[c]) begin
                checks++; if ({m_tlast, m_tdata} !== ed[c]) begin errors++; $display("FAIL simul_data c%0d: got %h want %h", c, {m_tlast, m_tdata}, ed[c]); end
            end
            if (s_tvalid[0] && s_tready[0]) b0++;
            if (s_tvalid[1] && s_tready[1]) b1++;
            next_cycle();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tvalid = '0;
        m_tready = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_reset_mid_packet();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
